vcache_fwd_trace_sched: RTL and testbench

//  Window-gated scheduler that gathers tile->vcache forward events from num_req_p tile tx monitors.

---
 rtl/vcache_fwd_trace_sched_pkg.sv | 22 ++
 rtl/vcache_fwd_trace_sched_rr.sv | 48 ++++
 rtl/vcache_fwd_trace_sched.sv | 168 ++++++++++++++++
 tb/tb_vcache_fwd_trace_sched.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vcache_fwd_trace_sched_pkg.sv
// rtl/vcache_fwd_trace_sched_pkg.sv - shared types and helpers for the vcache forward trace scheduler
// Contents: fwd_trace_state_e window FSM encoding, safe_clog2, is_vcache_row destination filter.
package vcache_fwd_trace_sched_pkg;

   typedef enum logic [1:0] {
      FT_IDLE    = 2'd0,
      FT_ARMED   = 2'd1,
      FT_CAPTURE = 2'd2,
      FT_DRAIN   = 2'd3
   } fwd_trace_state_e;

   // Width of an index into n items; never less than one bit.
   function automatic int safe_clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Vcache rows sit directly below the tile array and at the far edge.
   function automatic logic is_vcache_row(input logic [31:0] y, input int unsigned tiles_y);
      return (y == tiles_y - 1) || (y == 2 * tiles_y);
   endfunction

endpackage

// File: rtl/vcache_fwd_trace_sched_rr.sv
// rtl/vcache_fwd_trace_sched_rr.sv - round-robin arbiter with registered priority pointer
// Ports: clk_i, reset_i; reqs_i request vector; grant_en_i allows a grant this cycle;
//        grants_o one-hot grant; grant_id_o winner index; v_o some request present.
module vcache_fwd_trace_sched_rr
   import vcache_fwd_trace_sched_pkg::*;
#(
   parameter int num_req_p = 16,
   localparam int id_w_lp = safe_clog2(num_req_p)
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic [num_req_p-1:0] reqs_i,
   input  logic                 grant_en_i,
   output logic [num_req_p-1:0] grants_o,
   output logic [id_w_lp-1:0]   grant_id_o,
   output logic                 v_o
);

   logic [id_w_lp-1:0] ptr_r;
   int                 idx;

   // Scan starting at the pointer; first full request wins.
   always_comb begin
      v_o        = 1'b0;
      grant_id_o = '0;
      idx        = 0;
      for (int k = 0; k < num_req_p; k++) begin
         idx = (int'(ptr_r) + k) % num_req_p;
         if (!v_o && reqs_i[idx]) begin
            v_o        = 1'b1;
            grant_id_o = id_w_lp'(idx);
         end
      end
   end

   always_comb begin
      grants_o = '0;
      if (v_o && grant_en_i) grants_o[grant_id_o] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i)
         ptr_r <= '0;
      else if (v_o && grant_en_i)
         ptr_r <= (grant_id_o == id_w_lp'(num_req_p - 1)) ? '0 : grant_id_o + 1'b1;
   end

endmodule

// File: rtl/vcache_fwd_trace_sched.sv
// rtl/vcache_fwd_trace_sched.sv - window-gated round-robin scheduler for tile->vcache forward trace events
// Option macro: BSG_FWD_TRACE_DROP_CNT_EN enables the saturating drop counter (else drop_cnt_o = 0).
// Ports: clk_i, reset_i (sync, active high); global_ctr_i timestamp; cfg_v_i/cfg_start_i/cfg_stop_i window load;
//        req_v_i and flattened req_src_x/src_y/dst_x/dst_y_i per requester;
//        rec_v_o/rec_o/rec_yumi_i output record channel {ts, req_id, src_x, src_y, dst_x, dst_y};
//        state_o window FSM state; busy_o state != IDLE; drop_cnt_o dropped events.
module vcache_fwd_trace_sched
   import vcache_fwd_trace_sched_pkg::*;
#(
   parameter int num_req_p      = 16,
   parameter int x_cord_width_p = 7,
   parameter int y_cord_width_p = 7,
   parameter int num_tiles_y_p  = 8,
   localparam int req_id_w_lp   = safe_clog2(num_req_p),
   localparam int rec_width_lp  = 32 + req_id_w_lp + 2 * x_cord_width_p + 2 * y_cord_width_p
) (
   input  logic                                clk_i,
   input  logic                                reset_i,
   input  logic [31:0]                         global_ctr_i,
   input  logic                                cfg_v_i,
   input  logic [31:0]                         cfg_start_i,
   input  logic [31:0]                         cfg_stop_i,
   input  logic [num_req_p-1:0]                req_v_i,
   input  logic [num_req_p*x_cord_width_p-1:0] req_src_x_i,
   input  logic [num_req_p*y_cord_width_p-1:0] req_src_y_i,
   input  logic [num_req_p*x_cord_width_p-1:0] req_dst_x_i,
   input  logic [num_req_p*y_cord_width_p-1:0] req_dst_y_i,
   output logic                                rec_v_o,
   output logic [rec_width_lp-1:0]             rec_o,
   input  logic                                rec_yumi_i,
   output logic [1:0]                          state_o,
   output logic                                busy_o,
   output logic [31:0]                         drop_cnt_o
);

   typedef struct packed {
      logic [31:0]               ts;
      logic [req_id_w_lp-1:0]    req_id;
      logic [x_cord_width_p-1:0] src_x;
      logic [y_cord_width_p-1:0] src_y;
      logic [x_cord_width_p-1:0] dst_x;
      logic [y_cord_width_p-1:0] dst_y;
   } fwd_trace_rec_s;

   fwd_trace_state_e       state_r, state_n;
   logic [31:0]            start_r, stop_r;
   logic [num_req_p-1:0]   hold_v_r;
   fwd_trace_rec_s         hold_r [num_req_p];
   logic                   out_v_r;
   fwd_trace_rec_s         out_r;
   logic [num_req_p-1:0]   ev, load, grant;
   logic [req_id_w_lp-1:0] grant_id;
   logic                   grant_v, grant_en, grant_fire;
   logic                   cfg_accept, capture_ok;

   assign cfg_accept = cfg_v_i && (state_r == FT_IDLE);
   // The FSM leaves CAPTURE one edge after the counter reaches stop, so gate that cycle here.
   assign capture_ok = (state_r == FT_CAPTURE) && (global_ctr_i < stop_r);
   assign grant_en   = !out_v_r || rec_yumi_i;
   assign grant_fire = grant_v && grant_en;

   always_comb begin
      ev   = '0;
      load = '0;
      for (int i = 0; i < num_req_p; i++) begin
         ev[i]   = capture_ok && req_v_i[i]
                   && is_vcache_row(32'(req_dst_y_i[i*y_cord_width_p +: y_cord_width_p]), num_tiles_y_p);
         // A slot being granted this edge is free to take the new event.
         load[i] = ev[i] && (!hold_v_r[i] || grant[i]);
      end
   end

   vcache_fwd_trace_sched_rr #(.num_req_p(num_req_p)) arb (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .reqs_i     (hold_v_r),
      .grant_en_i (grant_en),
      .grants_o   (grant),
      .grant_id_o (grant_id),
      .v_o        (grant_v)
   );

   // FSM state register
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r <= FT_IDLE;
         start_r <= '0;
         stop_r  <= '0;
      end else begin
         state_r <= state_n;
         if (cfg_accept) begin
            start_r <= cfg_start_i;
            stop_r  <= cfg_stop_i;
         end
      end
   end

   // FSM next state
   always_comb begin
      state_n = state_r;
      case (state_r)
         FT_IDLE:    if (cfg_v_i) state_n = FT_ARMED;
         FT_ARMED:   if (global_ctr_i >= stop_r) state_n = FT_DRAIN;
                     else if (global_ctr_i >= start_r) state_n = FT_CAPTURE;
         FT_CAPTURE: if (global_ctr_i >= stop_r) state_n = FT_DRAIN;
         FT_DRAIN:   if ((hold_v_r == '0) && !out_v_r && !grant_fire && !rec_yumi_i) state_n = FT_IDLE;
         default:    state_n = FT_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      state_o = state_r;
      busy_o  = (state_r != FT_IDLE);
   end

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < num_req_p; i++) begin
         if (reset_i)       hold_v_r[i] <= 1'b0;
         else if (load[i])  hold_v_r[i] <= 1'b1;
         else if (grant[i]) hold_v_r[i] <= 1'b0;
         if (load[i])
            hold_r[i] <= '{ts:     global_ctr_i,
                           req_id: req_id_w_lp'(i),
                           src_x:  req_src_x_i[i*x_cord_width_p +: x_cord_width_p],
                           src_y:  req_src_y_i[i*y_cord_width_p +: y_cord_width_p],
                           dst_x:  req_dst_x_i[i*x_cord_width_p +: x_cord_width_p],
                           dst_y:  req_dst_y_i[i*y_cord_width_p +: y_cord_width_p]};
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i)         out_v_r <= 1'b0;
      else if (grant_fire) out_v_r <= 1'b1;
      else if (rec_yumi_i) out_v_r <= 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (grant_fire) out_r <= hold_r[grant_id];
   end

   assign rec_v_o = out_v_r;
   assign rec_o   = out_r;

`ifdef BSG_FWD_TRACE_DROP_CNT_EN
   logic [31:0] drop_pop;
   logic [32:0] drop_sum;
   logic [31:0] drop_cnt_r;

   always_comb begin
      drop_pop = '0;
      for (int i = 0; i < num_req_p; i++)
         drop_pop = drop_pop + 32'(ev[i] && !load[i]);
      drop_sum = {1'b0, drop_cnt_r} + {1'b0, drop_pop};
   end

   always_ff @(posedge clk_i) begin
      if (reset_i || cfg_accept) drop_cnt_r <= '0;
      else if (drop_sum[32])     drop_cnt_r <= '1;
      else                       drop_cnt_r <= drop_sum[31:0];
   end

   assign drop_cnt_o = drop_cnt_r;
`else
   assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_vcache_fwd_trace_sched.sv
// tb/tb_vcache_fwd_trace_sched.sv - scoreboard bench for vcache_fwd_trace_sched
module tb_vcache_fwd_trace_sched;

   localparam int N   = 16;
   localparam int XW  = 7;
   localparam int YW  = 7;
   localparam int TY  = 8;
   localparam int IDW = 4;
   localparam int RW  = 32 + IDW + 2 * XW + 2 * YW;

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   ctr;
   logic          cfg_v;
   logic [31:0]   cfg_start, cfg_stop;
   logic [N-1:0]  req_v;
   logic [N*XW-1:0] src_x, dst_x;
   logic [N*YW-1:0] src_y, dst_y;
   logic          rec_v;
   logic [RW-1:0] rec;
   logic          rec_yumi;
   logic          yumi_en;
   logic [1:0]    state;
   logic          busy;
   logic [31:0]   drop_cnt;

   int            n_cmp = 0;
   int            n_bad = 0;
   logic [RW-1:0] exp_q[$];
   logic [RW-1:0] exp_rec;
   int            xfer_cnt;
   logic [31:0]   first_xfer, last_xfer;
   logic [31:0]   exp_drop;

   always #5 clk = ~clk;
   assign rec_yumi = yumi_en & rec_v;

   vcache_fwd_trace_sched #(
      .num_req_p(N), .x_cord_width_p(XW), .y_cord_width_p(YW), .num_tiles_y_p(TY)
   ) dut (
      .clk_i(clk), .reset_i(reset), .global_ctr_i(ctr),
      .cfg_v_i(cfg_v), .cfg_start_i(cfg_start), .cfg_stop_i(cfg_stop),
      .req_v_i(req_v), .req_src_x_i(src_x), .req_src_y_i(src_y),
      .req_dst_x_i(dst_x), .req_dst_y_i(dst_y),
      .rec_v_o(rec_v), .rec_o(rec), .rec_yumi_i(rec_yumi),
      .state_o(state), .busy_o(busy), .drop_cnt_o(drop_cnt)
   );

   // Scoreboard: every accepted record must match the oldest expected one.
   always @(negedge clk) begin
      if (!reset && rec_v && rec_yumi) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL rec_unexpected: got %h, required no record", rec);
         end else begin
            exp_rec = exp_q.pop_front();
            if (rec !== exp_rec) begin
               n_bad++;
               $display("FAIL rec_data: got %h, required %h", rec, exp_rec);
            end
         end
         if (xfer_cnt == 0) first_xfer = ctr;
         last_xfer = ctr;
         xfer_cnt++;
      end
   end

   function automatic logic [RW-1:0] mk(input logic [31:0] ts, input int id, input logic [YW-1:0] dy);
      return {ts, IDW'(id), XW'(id), YW'(id + 1), XW'(id + 2), dy};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      ctr = ctr + 1;
   endtask

   task automatic run_to(input logic [31:0] c);
      while (ctr < c) tick();
   endtask

   task automatic fire(input int id, input logic [YW-1:0] dy, input bit push);
      req_v[id] = 1'b1;
      src_x[id*XW +: XW] = XW'(id);
      src_y[id*YW +: YW] = YW'(id + 1);
      dst_x[id*XW +: XW] = XW'(id + 2);
      dst_y[id*YW +: YW] = dy;
      if (push) exp_q.push_back(mk(ctr, id, dy));
   endtask

   task automatic do_reset();
      reset = 1'b1; cfg_v = 1'b0; req_v = '0; yumi_en = 1'b0;
      tick(); tick();
      reset = 1'b0;
      exp_q.delete();
      xfer_cnt = 0;
   endtask

   task automatic configure(input logic [31:0] s, input logic [31:0] e);
      cfg_v = 1'b1; cfg_start = s; cfg_stop = e;
      tick();
      cfg_v = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (state !== 2'd0 && n < 500) begin tick(); n++; end
      n_cmp++;
      if (state !== 2'd0) begin n_bad++; $display("FAIL %s_idle_timeout: state %0d, required 0", nm, state); end
   endtask

   task automatic check_state(input string nm, input logic [1:0] s);
      n_cmp++;
      if (state !== s) begin n_bad++; $display("FAIL %s: state %0d at ctr %0d, required %0d", nm, state, ctr, s); end
   endtask

   task automatic test_reset();
      ctr = 0; cfg_start = '0; cfg_stop = '0; src_x = '0; src_y = '0; dst_x = '0; dst_y = '0;
      do_reset();
      check_state("reset_state", 2'd0);
      n_cmp++; if (rec_v !== 1'b0)  begin n_bad++; $display("FAIL reset_rec_v: got %b, required 0", rec_v); end
      n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
      n_cmp++; if (drop_cnt !== 0)  begin n_bad++; $display("FAIL reset_drop: got %0d, required 0", drop_cnt); end
   endtask

   task automatic test_single();
      do_reset(); ctr = 90; yumi_en = 1'b1;
      configure(100, 200);
      check_state("single_armed", 2'd1);
      run_to(150);
      fire(3, YW'(TY - 1), 1'b1);
      tick(); req_v = '0;
      n_cmp++; if (rec_v !== 1'b0) begin n_bad++; $display("FAIL single_early: rec_v %b at ctr 151, required 0", rec_v); end
      tick();
      n_cmp++; if (rec_v !== 1'b1) begin n_bad++; $display("FAIL single_latency: rec_v %b at ctr 152, required 1", rec_v); end
      run_to(201);
      check_state("single_drain", 2'd3);
      tick();
      check_state("single_idle", 2'd0);
      n_cmp++; if (xfer_cnt !== 1 || exp_q.size() !== 0) begin
         n_bad++; $display("FAIL single_count: %0d records, %0d pending, required 1 and 0", xfer_cnt, exp_q.size());
      end
   endtask

   task automatic test_back_to_back();
      do_reset(); ctr = 90; yumi_en = 1'b1;
      configure(100, 200);
      run_to(120);
      for (int i = 0; i < N; i++) fire(i, (i % 2 == 1) ? YW'(2 * TY) : YW'(TY - 1), 1'b1);
      tick(); req_v = '0;
      run_to(140);
      n_cmp++; if (xfer_cnt !== N) begin n_bad++; $display("FAIL b2b_count: got %0d, required %0d", xfer_cnt, N); end
      n_cmp++; if (first_xfer !== 122 || last_xfer !== 137) begin
         n_bad++; $display("FAIL b2b_timing: first %0d last %0d, required 122 and 137", first_xfer, last_xfer);
      end
      n_cmp++; if (drop_cnt !== 0) begin n_bad++; $display("FAIL b2b_drop: got %0d, required 0", drop_cnt); end
   endtask

   task automatic test_drop();
`ifdef BSG_FWD_TRACE_DROP_CNT_EN
      exp_drop = 1;
`else
      exp_drop = 0;
`endif
      do_reset(); ctr = 90; yumi_en = 1'b0;
      configure(100, 200);
      run_to(130);
      fire(5, YW'(TY - 1), 1'b1); tick();   // loads empty slot
      fire(5, YW'(TY - 1), 1'b1); tick();   // slot granted same cycle, so it reloads
      fire(5, YW'(TY - 1), 1'b0); tick();   // slot full, output full: dropped
      req_v = '0;
      n_cmp++; if (drop_cnt !== exp_drop) begin n_bad++; $display("FAIL drop_cnt: got %0d, required %0d", drop_cnt, exp_drop); end
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (rec_v !== 1'b1 || rec !== mk(130, 5, YW'(TY - 1))) begin
            n_bad++; $display("FAIL drop_hold_stable: v %b rec %h, required 1 %h", rec_v, rec, mk(130, 5, YW'(TY - 1)));
         end
         tick();
      end
      yumi_en = 1'b1;
      run_to(145);
      n_cmp++; if (xfer_cnt !== 2 || exp_q.size() !== 0) begin
         n_bad++; $display("FAIL drop_records: %0d records, %0d pending, required 2 and 0", xfer_cnt, exp_q.size());
      end
      wait_idle("drop");
   endtask

   task automatic test_filtered();
      do_reset(); ctr = 90; yumi_en = 1'b1;
      configure(100, 200);
      run_to(99);  fire(2, YW'(TY - 1), 1'b0); tick(); req_v = '0;
      run_to(150); fire(4, YW'(3), 1'b0);      tick(); req_v = '0;
      run_to(200); fire(6, YW'(TY - 1), 1'b0); tick(); req_v = '0;
      wait_idle("filter");
      n_cmp++; if (xfer_cnt !== 0) begin n_bad++; $display("FAIL filter_count: got %0d, required 0", xfer_cnt); end
      n_cmp++; if (drop_cnt !== 0) begin n_bad++; $display("FAIL filter_drop: got %0d, required 0", drop_cnt); end
   endtask

   task automatic test_empty_window();
      do_reset(); ctr = 40; yumi_en = 1'b1;
      configure(50, 50);
      run_to(50);
      check_state("empty_armed", 2'd1);
      fire(1, YW'(TY - 1), 1'b0); tick(); req_v = '0;
      check_state("empty_drain", 2'd3);
      tick();
      check_state("empty_idle", 2'd0);
      n_cmp++; if (busy !== 1'b0 || xfer_cnt !== 0) begin
         n_bad++; $display("FAIL empty_result: busy %b records %0d, required 0 and 0", busy, xfer_cnt);
      end
      configure(60, 70);
      run_to(62);
      check_state("cfg_capture", 2'd2);
      configure(0, 0);
      check_state("cfg_ignored", 2'd2);
      run_to(66);
      check_state("cfg_ignored_late", 2'd2);
      run_to(71);
      check_state("cfg_orig_stop", 2'd3);
      tick();
      check_state("cfg_orig_idle", 2'd0);
   endtask

   task automatic test_reset_mid();
      do_reset(); ctr = 140; yumi_en = 1'b0;
      configure(100, 200);
      run_to(150);
      for (int i = 0; i < 4; i++) fire(i, YW'(TY - 1), 1'b1);
      tick(); req_v = '0;
      run_to(153);
      n_cmp++; if (rec_v !== 1'b1) begin n_bad++; $display("FAIL mid_buffered: rec_v %b, required 1", rec_v); end
      reset = 1'b1;
      tick();
      n_cmp++; if (rec_v !== 1'b0 || state !== 2'd0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL mid_reset: v %b state %0d busy %b, required 0 0 0", rec_v, state, busy);
      end
      reset = 1'b0;
      exp_q.delete(); xfer_cnt = 0; yumi_en = 1'b1;
      for (int k = 0; k < 10; k++) tick();
      n_cmp++; if (xfer_cnt !== 0 || rec_v !== 1'b0) begin
         n_bad++; $display("FAIL mid_leftover: %0d records v %b, required 0 and 0", xfer_cnt, rec_v);
      end
   endtask

   initial begin
      reset = 1'b1; cfg_v = 1'b0; req_v = '0; yumi_en = 1'b0; xfer_cnt = 0;
      test_reset();
      test_single();
      test_back_to_back();
      test_drop();
      test_filtered();
      test_empty_window();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
